// File: rtl/edge_event_logger_pkg.sv
// Shared types and default sizing for the edge event logger.
// Record layout, top to bottom: {ts, rise, fall, wrap}.
package edge_event_logger_pkg;

  localparam int CH_DEF       = 4;
  localparam int TS_WIDTH_DEF = 16;
  localparam int DEPTH_DEF    = 8;

  typedef enum logic {
    ARM,
    RUN
  } state_t;

  function automatic int rec_width(input int ch, input int ts_width);
    return ts_width + 2 * ch + 1;
  endfunction

  localparam int REC_W = rec_width(CH_DEF, TS_WIDTH_DEF);

  typedef struct packed {
    logic [TS_WIDTH_DEF-1:0] ts;
    logic [CH_DEF-1:0]       rise;
    logic [CH_DEF-1:0]       fall;
    logic                    wrap;
  } record_t;

endpackage

// File: rtl/edge_event_logger_fifo.sv
// Synchronous record FIFO. The head is read from registered storage, and a push
// into a full FIFO is accepted when a pop happens in the same cycle.
module event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: storage is deliberately not reset; only pointers and level are, and
  // dout is forced to zero while empty so nothing stale is ever presented.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/edge_event_logger.sv
// Edge event logger: detects rising/falling edges on CH signals each cycle and
// queues one timestamped record per active cycle for a valid/ready consumer.
module edge_event_logger
  import edge_event_logger_pkg::*;
#(
  parameter int CH       = CH_DEF,
  parameter int TS_WIDTH = TS_WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [CH-1:0]            sig,
  input  logic                     clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TS_WIDTH-1:0]      out_ts,
  output logic [CH-1:0]            out_rise,
  output logic [CH-1:0]            out_fall,
  output logic                     out_wrap,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic [7:0]               drop_cnt
);

  localparam int REC_WIDTH = rec_width(CH, TS_WIDTH);

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [CH-1:0]       rise;
    logic [CH-1:0]       fall;
    logic                wrap;
  } rec_t;

  state_t              state;
  logic [CH-1:0]       prev;
  logic [TS_WIDTH-1:0] ts;
  logic                wrap_pend;
  logic [CH-1:0]       rise;
  logic [CH-1:0]       fall;
  logic                push_req;
  logic                push;
  logic                pop;
  logic                drop;
  logic                wrap_now;
  logic                full;
  logic                empty;
  rec_t                wr_rec;
  rec_t                rd_rec;

  assign rise     = sig & ~prev;
  assign fall     = ~sig & prev;
  assign push_req = (state == RUN) && en && |(rise | fall);
  assign pop      = out_valid && out_ready;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // The wrap cycle is the one in which ts reads zero again; the zero seen in
  // ARM straight after reset is not a wrap.
  assign wrap_now = (state == RUN) && (ts == '0);

  assign wr_rec = '{ts: ts, rise: rise, fall: fall, wrap: wrap_pend};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARM;
      prev  <= '0;
      ts    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ts   <= ts + TS_WIDTH'(1);
      prev <= sig;
      case (state)
        ARM:     state <= RUN;
        RUN:     state <= RUN;
        default: state <= ARM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_pend <= 1'b0;
      ovf       <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (wrap_now)  wrap_pend <= 1'b1;
      else if (push) wrap_pend <= 1'b0;

      if (clr) begin
        ovf      <= 1'b0;
        drop_cnt <= '0;
      end else if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  event_fifo #(
    .WIDTH (REC_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (wr_rec),
    .dout  (rd_rec),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign out_valid = !empty;
  assign out_ts    = rd_rec.ts;
  assign out_rise  = rd_rec.rise;
  assign out_fall  = rd_rec.fall;
  assign out_wrap  = rd_rec.wrap;

endmodule

// File: tb/tb_edge_event_logger.sv
// Self-checking bench for edge_event_logger: queue-based reference model,
// per-cycle comparison, directed scenarios with literal expectations, random traffic.
module tb_edge_event_logger;

  localparam int CH       = 4;
  localparam int TS_WIDTH = 4;
  localparam int DEPTH    = 8;
  localparam int LW       = $clog2(DEPTH) + 1;
  localparam int TS_MOD   = 1 << TS_WIDTH;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                en = 1'b0;
  logic [CH-1:0]       sig = '0;
  logic                clr = 1'b0;
  logic                out_ready = 1'b0;
  logic                out_valid;
  logic [TS_WIDTH-1:0] out_ts;
  logic [CH-1:0]       out_rise;
  logic [CH-1:0]       out_fall;
  logic                out_wrap;
  logic [LW-1:0]       level;
  logic                ovf;
  logic [7:0]          drop_cnt;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  always #5 clk = ~clk;

  edge_event_logger #(
    .CH       (CH),
    .TS_WIDTH (TS_WIDTH),
    .DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sig       (sig),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ts    (out_ts),
    .out_rise  (out_rise),
    .out_fall  (out_fall),
    .out_wrap  (out_wrap),
    .level     (level),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles since reset give ts, a queue holds the records.
  typedef struct {
    int ts;
    int rise;
    int fall;
    int wrap;
  } m_rec_t;

  m_rec_t        mq[$];
  int            m_ts    = 0;
  bit            m_armed = 0;
  bit            m_pend  = 0;
  bit            m_ovf   = 0;
  int            m_drop  = 0;
  logic [CH-1:0] m_prev  = '0;
  logic [CH-1:0] m_r;
  logic [CH-1:0] m_f;
  m_rec_t        m_new;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_ts = 0; m_armed = 0; m_pend = 0; m_ovf = 0; m_drop = 0; m_prev = '0;
    end else begin
      if (!m_armed) begin
        m_armed = 1;
      end else begin
        m_r = sig & ~m_prev;
        m_f = ~sig & m_prev;
        if (mq.size() != 0 && out_ready) mq.delete(0);
        if (en && (m_r | m_f) != '0) begin
          if (mq.size() < DEPTH) begin
            m_new.ts   = m_ts;
            m_new.rise = int'(m_r);
            m_new.fall = int'(m_f);
            m_new.wrap = int'(m_pend);
            mq.push_back(m_new);
            m_pend = 0;
          end else if (!clr) begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
          end
        end
        if (m_ts == 0) m_pend = 1;
      end
      if (clr) begin
        m_ovf  = 0;
        m_drop = 0;
      end
      m_prev = sig;
      m_ts   = (m_ts + 1) % TS_MOD;
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("out_valid", out_valid, mq.size() != 0);
      check("level", level, mq.size());
      check("ovf", ovf, m_ovf);
      check("drop_cnt", drop_cnt, m_drop);
      if (mq.size() != 0) begin
        check("head_ts", out_ts, mq[0].ts);
        check("head_rise", out_rise, mq[0].rise);
        check("head_fall", out_fall, mq[0].fall);
        check("head_wrap", out_wrap, mq[0].wrap);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic wait_ts(input int t);
    for (int i = 0; i < 2 * TS_MOD && m_ts != t; i++) tick();
  endtask

  task automatic do_reset(input logic [CH-1:0] s);
    @(negedge clk);
    #2;
    rst_n = 1'b0; sig = s; en = 1'b1; clr = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_fields", {out_ts, out_rise, out_fall, out_wrap}, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic pop_check(input int t, input int r, input int f, input int w);
    at_neg();
    check("pop_valid", out_valid, 1);
    check("pop_ts", out_ts, t);
    check("pop_rise", out_rise, r);
    check("pop_fall", out_fall, f);
    if (w >= 0) check("pop_wrap", out_wrap, w);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    #1;
    rst_n = 1'b0;
    #1;
    cmp_en = 1;

    // No record after reset while sig is held.
    do_reset(4'b0101);
    repeat (20) tick();
    at_neg();
    check("t1_valid", out_valid, 0);
    check("t1_level", level, 0);

    // Basic records and one-cycle latency.
    do_reset(4'b0000);
    wait_ts(5);
    sig = 4'b0011;
    tick();
    at_neg();
    check("t2_valid", out_valid, 1);
    check("t2_level", level, 1);
    check("t2_ts", out_ts, 5);
    check("t2_rise", out_rise, 4'b0011);
    check("t2_fall", out_fall, 4'b0000);
    check("t2_wrap", out_wrap, 0);
    wait_ts(7);
    sig = 4'b0010;
    tick();
    pop_check(5, 4'b0011, 4'b0000, 0);
    pop_check(7, 4'b0000, 4'b0001, 0);
    at_neg();
    check("t2_empty", out_valid, 0);

    // en low: edges tracked but not recorded.
    en = 1'b0;
    sig = 4'b0000; tick();
    sig = 4'b1111; tick();
    sig = 4'b0110; tick();
    at_neg();
    check("t5_level_off", level, 0);
    en = 1'b1;
    repeat (3) tick();
    at_neg();
    check("t5_level_steady", level, 0);
    sig = 4'b0100;
    t = m_ts;
    tick();
    pop_check(t, 4'b0000, 4'b0010, -1);

    // Overflow, push+pop while full, clr, drop_cnt saturation.
    do_reset(4'b0000);
    tick();
    for (int i = 0; i < 9; i++) begin
      sig = sig ^ 4'b0001;
      tick();
    end
    at_neg();
    check("t3_level_full", level, 8);
    check("t3_ovf", ovf, 1);
    check("t3_drop", drop_cnt, 1);
    out_ready = 1'b1;
    sig = sig ^ 4'b0001;
    tick();
    out_ready = 1'b0;
    at_neg();
    check("t3_level_pp", level, 8);
    check("t3_drop_pp", drop_cnt, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    at_neg();
    check("t3_ovf_clr", ovf, 0);
    check("t3_drop_clr", drop_cnt, 0);
    check("t3_level_clr", level, 8);
    for (int i = 0; i < 270; i++) begin
      sig = sig ^ 4'b0001;
      tick();
    end
    at_neg();
    check("t3_drop_sat", drop_cnt, 255);

    // Timestamp wrap flag.
    do_reset(4'b0000);
    wait_ts(14); sig = 4'b0001; tick();
    wait_ts(2);  sig = 4'b0000; tick();
    wait_ts(0);  sig = 4'b0001; tick();
    wait_ts(3);  sig = 4'b0000; tick();
    pop_check(14, 4'b0001, 4'b0000, 0);
    pop_check(2,  4'b0000, 4'b0001, 1);
    pop_check(0,  4'b0001, 4'b0000, 0);
    pop_check(3,  4'b0000, 4'b0001, 1);

    // Reset mid-operation clears the queue at once.
    do_reset(4'b0000);
    tick();
    for (int i = 0; i < 3; i++) begin
      sig = sig ^ 4'b0001;
      tick();
    end
    at_neg();
    check("t6_level_pre", level, 3);
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    sig = 4'b0101;
    #1;
    check("t6_valid_rst", out_valid, 0);
    check("t6_level_rst", level, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (12) tick();
    at_neg();
    check("t6_valid_arm", out_valid, 0);
    check("t6_level_arm", level, 0);

    // Random traffic against the model.
    tick();
    for (int i = 0; i < 3000; i++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) == 0) sig = CH'($urandom);
      out_ready = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst_n = 1'b1;
    clr = 1'b0;
    tick();
    at_neg();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
